// File: rtl/uart.sv
// uart: baud tick generator, 8N1 transmitter and 16x-oversampling receiver fed by an internal loopback line.
// Optional even parity bit between data and stop when UART_PARITY_EN is defined.
module uart #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 54,
  parameter int DVSR_W  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       s_tick
);
  localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PAR,
`endif
    STOP
  } state_t;
  logic [DVSR_W-1:0] cnt;
  state_t tx_st, tx_st_n, rx_st, rx_st_n;
  logic [3:0] tx_s, tx_s_n, rx_s, rx_s_n;
  logic [NW-1:0] tx_n, tx_n_n, rx_n, rx_n_n;
  logic [DBIT-1:0] tx_b, tx_b_n, rx_b, rx_b_n;
  logic tx_line, tx_line_n, rx_done_n;
`ifdef UART_PARITY_EN
  logic tx_p, tx_p_n, rx_perr, rx_perr_n;
`endif
  assign s_tick = cnt == DVSR_W'(DVSR - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      tx_st        <= IDLE;
      tx_s         <= '0;
      tx_n         <= '0;
      tx_b         <= '0;
      tx_line      <= 1'b1;
      rx_st        <= IDLE;
      rx_s         <= '0;
      rx_n         <= '0;
      rx_b         <= '0;
      rx_done_tick <= 1'b0;
      dout         <= '0;
`ifdef UART_PARITY_EN
      tx_p         <= 1'b0;
      rx_perr      <= 1'b0;
`endif
    end else begin
      cnt          <= s_tick ? '0 : cnt + 1'b1;
      tx_st        <= tx_st_n;
      tx_s         <= tx_s_n;
      tx_n         <= tx_n_n;
      tx_b         <= tx_b_n;
      tx_line      <= tx_line_n;
      rx_st        <= rx_st_n;
      rx_s         <= rx_s_n;
      rx_n         <= rx_n_n;
      rx_b         <= rx_b_n;
      rx_done_tick <= rx_done_n;
      dout         <= rx_done_n ? 8'(rx_b) : dout;
`ifdef UART_PARITY_EN
      tx_p         <= tx_p_n;
      rx_perr      <= rx_perr_n;
`endif
    end
  end
  // Tick counters wrap 15 -> 0 by width, so a full 16-tick bit needs no explicit clear.
  always_comb begin
    tx_st_n      = tx_st;
    tx_s_n       = tx_s;
    tx_n_n       = tx_n;
    tx_b_n       = tx_b;
    tx_line_n    = 1'b1;
    tx_done_tick = 1'b0;
`ifdef UART_PARITY_EN
    tx_p_n       = tx_p;
`endif
    case (tx_st)
      IDLE: if (tx_start) begin
        tx_st_n = START;
        tx_s_n  = '0;
        tx_b_n  = din[DBIT-1:0];
`ifdef UART_PARITY_EN
        tx_p_n  = ^din[DBIT-1:0];
`endif
      end
      START: begin
        tx_line_n = 1'b0;
        if (s_tick) begin
          tx_s_n = tx_s + 1'b1;
          if (tx_s == 4'd15) begin
            tx_st_n = DATA;
            tx_n_n  = '0;
          end
        end
      end
      DATA: begin
        tx_line_n = tx_b[0];
        if (s_tick) begin
          tx_s_n = tx_s + 1'b1;
          if (tx_s == 4'd15) begin
            tx_b_n = tx_b >> 1;
            tx_n_n = tx_n + 1'b1;
`ifdef UART_PARITY_EN
            if (tx_n == NW'(DBIT - 1)) tx_st_n = PAR;
`else
            if (tx_n == NW'(DBIT - 1)) tx_st_n = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PAR: begin
        tx_line_n = tx_p;
        if (s_tick) begin
          tx_s_n = tx_s + 1'b1;
          if (tx_s == 4'd15) tx_st_n = STOP;
        end
      end
`endif
      STOP: if (s_tick) begin
        tx_s_n = tx_s + 1'b1;
        if (tx_s == 4'(SB_TICK - 1)) begin
          tx_st_n      = IDLE;
          tx_done_tick = 1'b1;
        end
      end
      default: tx_st_n = IDLE;
    endcase
  end
  // Receiver samples the registered tx line at mid-bit (s=7 in start, then every 16 ticks).
  always_comb begin
    rx_st_n   = rx_st;
    rx_s_n    = rx_s;
    rx_n_n    = rx_n;
    rx_b_n    = rx_b;
    rx_done_n = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_n = rx_perr;
`endif
    case (rx_st)
      IDLE: if (!tx_line) begin
        rx_st_n = START;
        rx_s_n  = '0;
      end
      START: if (s_tick) begin
        rx_s_n = rx_s + 1'b1;
        if (rx_s == 4'd7) begin
          rx_s_n  = '0;
          rx_n_n  = '0;
          rx_st_n = tx_line ? IDLE : DATA;
`ifdef UART_PARITY_EN
          rx_perr_n = 1'b0;
`endif
        end
      end
      DATA: if (s_tick) begin
        rx_s_n = rx_s + 1'b1;
        if (rx_s == 4'd15) begin
          rx_b_n = {tx_line, rx_b[DBIT-1:1]};
          rx_n_n = rx_n + 1'b1;
`ifdef UART_PARITY_EN
          if (rx_n == NW'(DBIT - 1)) rx_st_n = PAR;
`else
          if (rx_n == NW'(DBIT - 1)) rx_st_n = STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      PAR: if (s_tick) begin
        rx_s_n = rx_s + 1'b1;
        if (rx_s == 4'd15) begin
          rx_perr_n = tx_line ^ (^rx_b);
          rx_st_n   = STOP;
        end
      end
`endif
      STOP: if (s_tick) begin
        rx_s_n = rx_s + 1'b1;
        if (rx_s == 4'(SB_TICK - 1)) begin
          rx_st_n   = IDLE;
`ifdef UART_PARITY_EN
          rx_done_n = !rx_perr;
`else
          rx_done_n = 1'b1;
`endif
        end
      end
      default: rx_st_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart.sv
// tb_uart: loopback bench for uart; expected timing is derived from s_tick arithmetic over a cycle index.
module tb_uart;
  localparam int DVSR = 7;
`ifdef UART_PARITY_EN
  localparam int FT = 176;
`else
  localparam int FT = 160;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic tx_done_tick, rx_done_tick, s_tick;
  logic [7:0] dout;
  int total = 0;
  int bad = 0;
  int mcyc = 0;
  int tx_q[$];
  int rx_c[$];
  logic [7:0] rx_d[$];

  uart #(.DBIT(8), .SB_TICK(16), .DVSR(DVSR), .DVSR_W(8)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .din(din),
    .tx_done_tick(tx_done_tick), .rx_done_tick(rx_done_tick), .dout(dout), .s_tick(s_tick)
  );

  always #5 clk = ~clk;

  // mcyc indexes cycles since reset release; cycle i carries a tick when i % DVSR == DVSR-1.
  always @(negedge clk) begin
    if (!reset) mcyc <= 0;
    else begin
      if (tx_done_tick) tx_q.push_back(mcyc);
      if (rx_done_tick) begin
        rx_c.push_back(mcyc);
        rx_d.push_back(dout);
      end
      mcyc <= mcyc + 1;
    end
  end

  function automatic int ticks(input int a, input int b);
    return (b + 1) / DVSR - a / DVSR;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q();
    tx_q.delete();
    rx_c.delete();
    rx_d.delete();
  endtask

  task automatic start_frame(input logic [7:0] b, output int k);
    step();
    din = b;
    tx_start = 1'b1;
    k = mcyc - 1;
    step();
    tx_start = 1'b0;
  endtask

  task automatic wait_frame(output bit ok, output int d);
    ok = 1'b0;
    d = -1;
    for (int i = 0; i < (FT + 40) * DVSR && !ok; i++) begin
      step();
      if (tx_q.size() > 0) begin
        ok = 1'b1;
        d = tx_q.pop_front();
      end
    end
  endtask

  task automatic test_reset();
    int first, per;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++; if (tx_done_tick !== 1'b0) begin bad++; $display("FAIL reset_tx_done got=%b exp=0", tx_done_tick); end
    total++; if (rx_done_tick !== 1'b0) begin bad++; $display("FAIL reset_rx_done got=%b exp=0", rx_done_tick); end
    total++; if (s_tick !== 1'b0) begin bad++; $display("FAIL reset_s_tick got=%b exp=0", s_tick); end
    @(posedge clk);
    #1 reset = 1'b1;
    first = -1;
    for (int i = 0; i < 3 * DVSR && first < 0; i++) begin
      @(negedge clk);
      if (s_tick) first = i;
    end
    total++; if (first != DVSR - 1) begin bad++; $display("FAIL first_tick got=%0d exp=%0d", first, DVSR - 1); end
    for (int p = 0; p < 3; p++) begin
      per = -1;
      for (int i = 1; i <= 3 * DVSR && per < 0; i++) begin
        @(negedge clk);
        if (s_tick) per = i;
      end
      total++; if (per != DVSR) begin bad++; $display("FAIL tick_period got=%0d exp=%0d", per, DVSR); end
    end
  endtask

  task automatic test_single();
    int k, d, c, lead;
    bit ok;
    logic [7:0] v;
    clear_q();
    start_frame(8'hB2, k);
    wait_frame(ok, d);
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout got=none exp=tx_done"); end
    else begin
      total++; if (ticks(k + 1, d) != FT) begin bad++; $display("FAIL single_ticks got=%0d exp=%0d", ticks(k + 1, d), FT); end
      total++;
      if (rx_c.size() != 1) begin bad++; $display("FAIL single_rx_count got=%0d exp=1", rx_c.size()); end
      else begin
        c = rx_c.pop_front();
        v = rx_d.pop_front();
        lead = ticks(c, d);
        total++; if (v !== 8'hB2) begin bad++; $display("FAIL single_data got=%h exp=b2", v); end
        total++; if (c >= d || lead < 6 || lead > 10) begin bad++; $display("FAIL single_rx_lead got=%0d exp=6..10", lead); end
      end
    end
    repeat ((FT + 20) * DVSR) step();
    total++; if (tx_q.size() + rx_c.size() != 0) begin bad++; $display("FAIL single_extra got=%0d exp=0", tx_q.size() + rx_c.size()); end
    total++; if (dout !== 8'hB2) begin bad++; $display("FAIL single_hold got=%h exp=b2", dout); end
  endtask

  task automatic test_edge_data();
    logic [7:0] pat [8];
    int k, d;
    bit ok;
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h01; pat[3] = 8'h80;
    for (int i = 4; i < 8; i++) pat[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      clear_q();
      repeat ($urandom_range(0, 3 * DVSR)) step();
      start_frame(pat[i], k);
      wait_frame(ok, d);
      repeat (2) step();
      total++;
      if (!ok) begin bad++; $display("FAIL edge_timeout[%0d] got=none exp=tx_done", i); end
      else begin
        total++; if (ticks(k + 1, d) != FT) begin bad++; $display("FAIL edge_ticks[%0d] got=%0d exp=%0d", i, ticks(k + 1, d), FT); end
        total++; if (tx_q.size() != 0) begin bad++; $display("FAIL edge_tx_count[%0d] got=%0d exp=1", i, tx_q.size() + 1); end
        total++;
        if (rx_c.size() != 1) begin bad++; $display("FAIL edge_rx_count[%0d] got=%0d exp=1", i, rx_c.size()); end
        else begin
          total++; if (rx_d[0] !== pat[i]) begin bad++; $display("FAIL edge_data[%0d] got=%h exp=%h", i, rx_d[0], pat[i]); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int k, n;
    clear_q();
    step();
    din = 8'hB2;
    tx_start = 1'b1;
    k = mcyc - 1;
    for (int i = 0; i < 4 * FT * DVSR && tx_q.size() < 3; i++) step();
    tx_start = 1'b0;
    repeat ((FT + 20) * DVSR) step();
    total++;
    if (tx_q.size() != 3) begin bad++; $display("FAIL b2b_tx_count got=%0d exp=3", tx_q.size()); end
    else begin
      total++; if (ticks(k + 1, tx_q[0]) != FT) begin bad++; $display("FAIL b2b_first got=%0d exp=%0d", ticks(k + 1, tx_q[0]), FT); end
      for (int i = 1; i < 3; i++) begin
        n = ticks(tx_q[i - 1] + 1, tx_q[i]);
        total++; if (n != FT) begin bad++; $display("FAIL b2b_tx_gap[%0d] got=%0d exp=%0d", i, n, FT); end
      end
    end
    total++;
    if (rx_c.size() != 3) begin bad++; $display("FAIL b2b_rx_count got=%0d exp=3", rx_c.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++; if (rx_d[i] !== 8'hB2) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=b2", i, rx_d[i]); end
      if (i > 0) begin
        n = ticks(rx_c[i - 1] + 1, rx_c[i]);
        total++; if (n < FT - 1 || n > FT + 1) begin bad++; $display("FAIL b2b_rx_gap[%0d] got=%0d exp=%0d+-1", i, n, FT); end
      end
    end
  endtask

  task automatic test_mid_reset();
    int k, d;
    bit ok;
    clear_q();
    start_frame(8'h5A, k);
    repeat (64 * DVSR) step();
    total++; if (dout !== 8'hB2) begin bad++; $display("FAIL midrst_inflight_dout got=%h exp=b2", dout); end
    reset = 1'b0;
    step();
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL midrst_dout got=%h exp=00", dout); end
    total++; if (tx_done_tick !== 1'b0 || rx_done_tick !== 1'b0) begin bad++; $display("FAIL midrst_ticks got=%b%b exp=00", tx_done_tick, rx_done_tick); end
    step();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat ((FT + 20) * DVSR) step();
    total++; if (tx_q.size() + rx_c.size() != 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", tx_q.size() + rx_c.size()); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL midrst_after_dout got=%h exp=00", dout); end
    clear_q();
    start_frame(8'h3C, k);
    wait_frame(ok, d);
    total++;
    if (!ok) begin bad++; $display("FAIL midrst_timeout got=none exp=tx_done"); end
    else begin
      total++; if (ticks(k + 1, d) != FT) begin bad++; $display("FAIL midrst_ticks got=%0d exp=%0d", ticks(k + 1, d), FT); end
      total++;
      if (rx_c.size() != 1) begin bad++; $display("FAIL midrst_rx_count got=%0d exp=1", rx_c.size()); end
      else begin
        total++; if (rx_d[0] !== 8'h3C) begin bad++; $display("FAIL midrst_data got=%h exp=3c", rx_d[0]); end
      end
    end
  endtask

  task automatic test_din_change();
    int k, d;
    bit ok;
    clear_q();
    start_frame(8'hA5, k);
    repeat (40 * DVSR) step();
    din = 8'h00;
    repeat (30 * DVSR) step();
    din = 8'($urandom);
    wait_frame(ok, d);
    total++;
    if (!ok) begin bad++; $display("FAIL dinchg_timeout got=none exp=tx_done"); end
    else begin
      total++;
      if (rx_c.size() != 1) begin bad++; $display("FAIL dinchg_rx_count got=%0d exp=1", rx_c.size()); end
      else begin
        total++; if (rx_d[0] !== 8'hA5) begin bad++; $display("FAIL dinchg_data got=%h exp=a5", rx_d[0]); end
      end
      total++; if (dout !== 8'hA5) begin bad++; $display("FAIL dinchg_dout got=%h exp=a5", dout); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_edge_data();
    test_back_to_back();
    test_mid_reset();
    test_din_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
